// File: rtl/jedro_1_defines.sv
// Shared constants for the jedro_1 decode stage: width defaults, RV32I opcodes, ALU op codes
// and the decoder FSM state encoding.
package jedro_1_defines;

    localparam int unsigned DefDataWidth    = 32;
    localparam int unsigned DefRegAddrWidth = 5;
    localparam int unsigned DefAluOpWidth   = 4;

    localparam logic [6:0] OpcodeOp    = 7'b0110011;
    localparam logic [6:0] OpcodeOpImm = 7'b0010011;
    localparam logic [6:0] OpcodeLui   = 7'b0110111;
    localparam logic [6:0] OpcodeAuipc = 7'b0010111;

    localparam logic [6:0] Funct7Zero = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSll = 4'b0001;
    localparam logic [3:0] AluSrl = 4'b0101;
    localparam logic [3:0] AluSub = 4'b1000;
    localparam logic [3:0] AluSra = 4'b1101;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StValid = 2'd2
    } dec_state_e;

endpackage

// File: rtl/jedro_1_imm_gen.sv
// Combinational I-type (sign-extended imm[11:0]) and U-type ({imm[31:12], 12'b0}) immediates.
module jedro_1_imm_gen #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] imm_itype,
    output logic [DATA_WIDTH-1:0] imm_utype
);

    assign imm_itype = DATA_WIDTH'($signed(instr[31:20]));
    assign imm_utype = DATA_WIDTH'($signed({instr[31:12], 12'b0}));

endmodule

// File: rtl/jedro_1_decode_stage.sv
// jedro_1 decode stage: accepts an instruction, reads rs1/rs2 from a sync-read RF, registers
// ALU operands/op/rd/illegal for execute. Define JEDRO_1_RV32E_EN to restrict to x0-x15.
module jedro_1_decode_stage #(
    parameter int unsigned DATA_WIDTH     = jedro_1_defines::DefDataWidth,
    parameter int unsigned REG_ADDR_WIDTH = jedro_1_defines::DefRegAddrWidth,
    parameter int unsigned ALU_OP_WIDTH   = jedro_1_defines::DefAluOpWidth
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [DATA_WIDTH-1:0]     instr_rdata_i,
    input  logic [DATA_WIDTH-1:0]     instr_pc_i,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_raddr_a_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_raddr_b_o,
    input  logic [DATA_WIDTH-1:0]     rf_rdata_a_i,
    input  logic [DATA_WIDTH-1:0]     rf_rdata_b_i,
    input  logic                      flush_i,
    output logic                      dec_valid_o,
    input  logic                      dec_ready_i,
    output logic [ALU_OP_WIDTH-1:0]   alu_op_sel_o,
    output logic [DATA_WIDTH-1:0]     alu_op_a_o,
    output logic [DATA_WIDTH-1:0]     alu_op_b_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic                      rd_we_o,
    output logic                      illegal_instr_o
);
    import jedro_1_defines::*;

    dec_state_e            state_q;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  accept;

    logic [DATA_WIDTH-1:0]   imm_itype;
    logic [DATA_WIDTH-1:0]   imm_utype;
    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic [DATA_WIDTH-1:0]   dec_a;
    logic [DATA_WIDTH-1:0]   dec_b;
    logic [ALU_OP_WIDTH-1:0] dec_op;
    logic                    dec_illegal;
    logic                    dec_we;

    // Reset also blocks acceptance so every output reads 0 while rstn_i is low.
    assign instr_ready_o = rstn_i & ~flush_i
                         & ((state_q == StIdle) | ((state_q == StValid) & dec_ready_i));
    assign accept        = instr_valid_i & instr_ready_o;

    assign rf_raddr_a_o = accept ? instr_rdata_i[19:15] : instr_q[19:15];
    assign rf_raddr_b_o = accept ? instr_rdata_i[24:20] : instr_q[24:20];

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign rd     = instr_q[11:7];

    jedro_1_imm_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_imm_gen (
        .instr    (instr_q[31:0]),
        .imm_itype(imm_itype),
        .imm_utype(imm_utype)
    );

    always_comb begin
        dec_a       = '0;
        dec_b       = '0;
        dec_op      = '0;
        dec_illegal = 1'b0;
        if (instr_q[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opcode)
                OpcodeOp: begin
                    dec_a  = rf_rdata_a_i;
                    dec_b  = rf_rdata_b_i;
                    dec_op = {funct7[5], funct3};
                    if ((funct7 != Funct7Zero) && (funct7 != Funct7Alt)) dec_illegal = 1'b1;
                    if ((funct7 == Funct7Alt) && (funct3 != 3'b000) && (funct3 != 3'b101)) begin
                        dec_illegal = 1'b1;
                    end
                end
                OpcodeOpImm: begin
                    dec_a  = rf_rdata_a_i;
                    dec_b  = imm_itype;
                    dec_op = {1'b0, funct3};
                    // Shifts carry only shamt as operand; funct7[5] moves into the op select.
                    if (funct3 == AluSll[2:0]) begin
                        dec_b = {{(DATA_WIDTH-5){1'b0}}, rs2};
                        if (funct7 != Funct7Zero) dec_illegal = 1'b1;
                    end else if (funct3 == AluSrl[2:0]) begin
                        dec_b  = {{(DATA_WIDTH-5){1'b0}}, rs2};
                        dec_op = {funct7[5], funct3};
                        if ((funct7 != Funct7Zero) && (funct7 != Funct7Alt)) dec_illegal = 1'b1;
                    end
                end
                OpcodeLui: begin
                    dec_b  = imm_utype;
                    dec_op = AluAdd;
                end
                OpcodeAuipc: begin
                    dec_a  = pc_q;
                    dec_b  = imm_utype;
                    dec_op = AluAdd;
                end
                default: dec_illegal = 1'b1;
            endcase
        end
`ifdef JEDRO_1_RV32E_EN
        if (rd[4] | (rs1[4] & ((opcode == OpcodeOp) | (opcode == OpcodeOpImm)))
                  | (rs2[4] & (opcode == OpcodeOp))) begin
            dec_illegal = 1'b1;
        end
`endif
        if (dec_illegal) begin
            dec_a  = '0;
            dec_b  = '0;
            dec_op = '0;
        end
        dec_we = ~dec_illegal & (rd != 5'd0);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q         <= StIdle;
            instr_q         <= '0;
            pc_q            <= '0;
            dec_valid_o     <= 1'b0;
            alu_op_sel_o    <= '0;
            alu_op_a_o      <= '0;
            alu_op_b_o      <= '0;
            rd_addr_o       <= '0;
            rd_we_o         <= 1'b0;
            illegal_instr_o <= 1'b0;
        end else if (flush_i) begin
            state_q     <= StIdle;
            dec_valid_o <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        instr_q <= instr_rdata_i;
                        pc_q    <= instr_pc_i;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    alu_op_a_o      <= dec_a;
                    alu_op_b_o      <= dec_b;
                    alu_op_sel_o    <= dec_op;
                    rd_addr_o       <= rd;
                    rd_we_o         <= dec_we;
                    illegal_instr_o <= dec_illegal;
                    dec_valid_o     <= 1'b1;
                    state_q         <= StValid;
                end
                StValid: begin
                    if (dec_ready_i) begin
                        dec_valid_o <= 1'b0;
                        if (accept) begin
                            instr_q <= instr_rdata_i;
                            pc_q    <= instr_pc_i;
                            state_q <= StRead;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_jedro_1_decode_stage.sv
// Directed bench for jedro_1_decode_stage with a small synchronous-read register file model.
module tb_jedro_1_decode_stage;

    logic        clk;
    logic        rstn;
    logic [31:0] instr_rdata;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  rf_raddr_a;
    logic [4:0]  rf_raddr_b;
    logic [31:0] rf_rdata_a;
    logic [31:0] rf_rdata_b;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  alu_op_sel;
    logic [31:0] alu_op_a;
    logic [31:0] alu_op_b;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal_instr;

    int checks = 0;
    int errors = 0;

    jedro_1_decode_stage dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .instr_rdata_i  (instr_rdata),
        .instr_pc_i     (instr_pc),
        .instr_valid_i  (instr_valid),
        .instr_ready_o  (instr_ready),
        .rf_raddr_a_o   (rf_raddr_a),
        .rf_raddr_b_o   (rf_raddr_b),
        .rf_rdata_a_i   (rf_rdata_a),
        .rf_rdata_b_i   (rf_rdata_b),
        .flush_i        (flush),
        .dec_valid_o    (dec_valid),
        .dec_ready_i    (dec_ready),
        .alu_op_sel_o   (alu_op_sel),
        .alu_op_a_o     (alu_op_a),
        .alu_op_b_o     (alu_op_b),
        .rd_addr_o      (rd_addr),
        .rd_we_o        (rd_we),
        .illegal_instr_o(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rf_value(input logic [4:0] addr);
        case (addr)
            5'd1:    return 32'd5;
            5'd2:    return 32'd7;
            5'd5:    return 32'h8000_0000;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        rf_rdata_a <= rf_value(rf_raddr_a);
        rf_rdata_b <= rf_value(rf_raddr_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present an instruction for one cycle and step to the cycle where dec_valid should rise.
    task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        instr_rdata = instr;
        instr_pc    = pc;
        instr_valid = 1'b1;
        #1;
        check({tag, " ready"}, {31'd0, instr_ready}, 32'd1);
        check({tag, " raddr_a"}, {27'd0, rf_raddr_a}, {27'd0, instr[19:15]});
        check({tag, " raddr_b"}, {27'd0, rf_raddr_b}, {27'd0, instr[24:20]});
        @(negedge clk);
        instr_valid = 1'b0;
        check({tag, " valid_read"}, {31'd0, dec_valid}, 32'd0);
        @(negedge clk);
        check({tag, " valid"}, {31'd0, dec_valid}, 32'd1);
    endtask

    task automatic expect_bundle(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic [4:0] rd, input logic we,
                                 input logic ill);
        check({tag, " a"}, alu_op_a, a);
        check({tag, " b"}, alu_op_b, b);
        check({tag, " op"}, {28'd0, alu_op_sel}, {28'd0, op});
        check({tag, " rd"}, {27'd0, rd_addr}, {27'd0, rd});
        check({tag, " we"}, {31'd0, rd_we}, {31'd0, we});
        check({tag, " illegal"}, {31'd0, illegal_instr}, {31'd0, ill});
    endtask

    task automatic retire(input string tag);
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        check({tag, " retired"}, {31'd0, dec_valid}, 32'd0);
    endtask

    initial begin
        rstn        = 1'b0;
        instr_rdata = 32'd0;
        instr_pc    = 32'd0;
        instr_valid = 1'b0;
        flush       = 1'b0;
        dec_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst ready_low", {31'd0, instr_ready}, 32'd0);
        rstn = 1'b1;
        #1;
        check("rst ready", {31'd0, instr_ready}, 32'd1);
        check("rst valid", {31'd0, dec_valid}, 32'd0);
        expect_bundle("rst", 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);

        issue("add", 32'h0020_81B3, 32'h0000_0000);
        expect_bundle("add", 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0);
        retire("add");

        issue("addi", 32'hFFF0_0093, 32'h0000_0004);
        expect_bundle("addi", 32'd0, 32'hFFFF_FFFF, 4'b0000, 5'd1, 1'b1, 1'b0);
        retire("addi");

        issue("srai", 32'h4032_D293, 32'h0000_0008);
        expect_bundle("srai", 32'h8000_0000, 32'd3, 4'b1101, 5'd5, 1'b1, 1'b0);
        retire("srai");

        issue("lui", 32'h1234_5137, 32'h0000_000C);
        expect_bundle("lui", 32'd0, 32'h1234_5000, 4'b0000, 5'd2, 1'b1, 1'b0);
        retire("lui");

        issue("auipc", 32'h0000_1217, 32'h0000_0100);
        expect_bundle("auipc", 32'h0000_0100, 32'h0000_1000, 4'b0000, 5'd4, 1'b1, 1'b0);
        retire("auipc");

        issue("sub", 32'h4011_0333, 32'h0000_0110);
        expect_bundle("sub", 32'd7, 32'd5, 4'b1000, 5'd6, 1'b1, 1'b0);
        retire("sub");

        issue("bad_alt", 32'h4020_9233, 32'h0000_0114);
        expect_bundle("bad_alt", 32'd0, 32'd0, 4'd0, 5'd4, 1'b0, 1'b1);
        retire("bad_alt");

        // All-zero word, stalled by execute while the next instruction waits at the input.
        issue("zero", 32'h0000_0000, 32'h0000_0118);
        instr_rdata = 32'h0020_88B3;
        instr_pc    = 32'h0000_011C;
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("zero stall_ready", {31'd0, instr_ready}, 32'd0);
            check("zero stall_valid", {31'd0, dec_valid}, 32'd1);
            expect_bundle("zero stall", 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b1);
            @(negedge clk);
        end
        dec_ready = 1'b1;
        #1;
        check("b2b ready", {31'd0, instr_ready}, 32'd1);
        check("b2b raddr_a", {27'd0, rf_raddr_a}, 32'd1);
        @(negedge clk);
        dec_ready   = 1'b0;
        instr_valid = 1'b0;
        check("b2b valid_read", {31'd0, dec_valid}, 32'd0);
        @(negedge clk);
        check("b2b valid", {31'd0, dec_valid}, 32'd1);
`ifdef JEDRO_1_RV32E_EN
        expect_bundle("add_x17", 32'd0, 32'd0, 4'd0, 5'd17, 1'b0, 1'b1);
`else
        expect_bundle("add_x17", 32'd5, 32'd7, 4'b0000, 5'd17, 1'b1, 1'b0);
`endif
        retire("add_x17");

        // Flush while in READ.
        instr_rdata = 32'h0020_81B3;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        flush       = 1'b1;
        #1;
        check("flush ready", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush valid", {31'd0, dec_valid}, 32'd0);
        check("flush idle_ready", {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        check("flush valid_later", {31'd0, dec_valid}, 32'd0);

        // Asynchronous reset while holding a valid bundle.
        issue("rst_mid", 32'h0020_81B3, 32'h0000_0200);
        rstn = 1'b0;
        #1;
        check("rst_mid valid", {31'd0, dec_valid}, 32'd0);
        check("rst_mid ready", {31'd0, instr_ready}, 32'd0);
        expect_bundle("rst_mid", 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_mid release_ready", {31'd0, instr_ready}, 32'd1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jedro_1_decode_stage.md
Name: jedro_1_decode_stage

Overview:
- Parametrised, pipelined successor decoder for the jedro_1 core.
- Accepts one RV32I instruction and its PC through a valid/ready handshake.
- Reads both source registers from a synchronous-read register file, then builds ALU operands, ALU op select, destination and illegal flag.
- Presents the result to the execute stage through a second valid/ready handshake. Sits between the instruction LSU and the ALU/writeback.

Parameters:
- DATA_WIDTH, 32, operand/instruction/PC width.
- REG_ADDR_WIDTH, 5, register-file address width.
- ALU_OP_WIDTH, 4, ALU op select width: {funct7[5], funct3}.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- instr_rdata_i  in  DATA_WIDTH  instruction word.
- instr_pc_i  in  DATA_WIDTH  PC of instr_rdata_i.
- instr_valid_i  in  1  instruction word/PC valid.
- instr_ready_o  out  1  decoder accepts this cycle.
- rf_raddr_a_o  out  REG_ADDR_WIDTH  rs1 read address.
- rf_raddr_b_o  out  REG_ADDR_WIDTH  rs2 read address.
- rf_rdata_a_i  in  DATA_WIDTH  rs1 data, valid one cycle after address.
- rf_rdata_b_i  in  DATA_WIDTH  rs2 data, valid one cycle after address.
- flush_i  in  1  synchronous pipeline flush.
- dec_valid_o  out  1  decoded bundle valid.
- dec_ready_i  in  1  execute stage accepts bundle.
- alu_op_sel_o  out  ALU_OP_WIDTH  ALU operation.
- alu_op_a_o  out  DATA_WIDTH  operand A.
- alu_op_b_o  out  DATA_WIDTH  operand B.
- rd_addr_o  out  REG_ADDR_WIDTH  destination register.
- rd_we_o  out  1  write-back enable.
- illegal_instr_o  out  1  instruction illegal/unsupported.

Behaviour:
- FSM states: IDLE, READ, VALID.
- Reset (rstn_i low, asynchronous): state IDLE. All outputs and internal registers 0; instr_ready_o=1 after reset release.
- instr_ready_o = !flush_i & (IDLE | (VALID & dec_ready_i)).
- Accept on instr_valid_i & instr_ready_o:
  - Latch instruction and PC.
  - rf_raddr_a_o/b_o driven combinationally from instr_rdata_i[19:15]/[24:20] in the accept cycle; otherwise from the latched word.
  - Next state READ.
- READ (one cycle): RF data valid. Register operands, op, rd, we, illegal. Next state VALID.
- VALID: dec_valid_o=1 and all outputs held stable until dec_ready_i.
  - On handshake with a new accept in the same cycle: next state READ.
  - On handshake without a new accept: next state IDLE.
- Latency: accept edge to dec_valid_o = 2 cycles. Throughput: 1 instruction per 2 cycles.
- flush_i (any state): next state IDLE and dec_valid_o=0 next cycle. Flush overrides an accept and an output handshake in the same cycle.
- Decode rules:
  - OP: a=rs1, b=rs2, op={funct7[5],funct3}.
  - OP-IMM: a=rs1, b=sign-extended imm[11:0]. op={funct7[5],funct3} for funct3=101; otherwise {0,funct3}.
  - LUI: a=0, b={imm[31:12],12'b0}, op=ADD (0000).
  - AUIPC: a=PC, b={imm[31:12],12'b0}, op=ADD.
- rd_we_o=1 only for a legal instruction with rd!=0.
- Illegal (illegal_instr_o=1, rd_we_o=0, a=b=op=0):
  - instr[1:0]!=11.
  - Any other opcode (load/store/branch/jump/system/misc-mem are unsupported in this generation).
  - OP with funct7 not in {0000000,0100000}.
  - OP with funct7=0100000 and funct3 not in {000,101}.
  - OP-IMM shift (funct3 001/101) with funct7 not legal for that shift.
- Illegal bundles still complete the handshake.

Optional Feature:
- JEDRO_1_RV32E_EN defined: RV32E decoding. Any used rs1/rs2/rd with bit 4 set is illegal.
- JEDRO_1_RV32E_EN undefined: all 32 registers legal.

Decomposition:
- Shared package jedro_1_defines: opcode constants, ALU op codes, DATA_WIDTH/REG_ADDR_WIDTH/ALU_OP_WIDTH defaults, FSM state encodings.
- One combinational sub-module, jedro_1_imm_gen: produces the I- and U-type immediates.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), RF x1=5, x2=7 -> 2 cycles after accept: dec_valid_o=1, a=5, b=7, op=0000, rd=3, we=1.
- ADDI x1,x0,-1 (0xFFF00093) -> a=0, b=0xFFFFFFFF, op=0000, rd=1, we=1.
- SRAI x5,x5,3 (0x4032D293), RF x5=0x80000000 -> op=1101, a=0x80000000, b=3. LUI x2,0x12345 (0x12345137) -> a=0, b=0x12345000, op=0000.
- 0x00000000 with dec_ready_i low for 3 cycles -> illegal_instr_o=1, we=0, outputs stable, instr_ready_o=0 until handshake.
- flush_i in READ -> no dec_valid_o, IDLE next cycle. rstn_i low mid-VALID -> all outputs 0 immediately.
- With JEDRO_1_RV32E_EN: ADD x17,x1,x2 (0x002088B3) -> illegal_instr_o=1. Without the macro -> legal, rd=17.
